// File: rtl/life_row_seeder.sv
// life_row_seeder: builds an N-bit cell row holding exactly K live cells.
// A 16-bit Fibonacci LFSR picks candidate cells one bit per clock. Once the
// remaining quota equals the remaining slots, every later cell is forced live,
// so the row always ends with min(K, N) ones.
module life_row_seeder #(
  parameter int          VECTOR_LENGTH = 8,
  parameter logic [15:0] LFSR_RESET    = 16'hACE1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(VECTOR_LENGTH+1)-1:0]   ones_req,
  input  logic [15:0]                          seed,
  output logic                                 busy,
  output logic                                 done,
  output logic [VECTOR_LENGTH-1:0]             vector_out,
  output logic [$clog2(VECTOR_LENGTH+1)-1:0]   count_out
);

  localparam int CW = $clog2(VECTOR_LENGTH + 1);
  localparam logic [CW-1:0] N_VAL    = CW'(VECTOR_LENGTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(VECTOR_LENGTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   state_reg;
  logic [CW-1:0]            idx_reg;
  logic [CW-1:0]            rem_reg;
  logic [CW-1:0]            placed_reg;
  logic [VECTOR_LENGTH-1:0] work_reg;
  logic [15:0]              lfsr_reg;

  logic [CW-1:0]            slots;
  logic                     set_bit;
  logic [CW-1:0]            clamped_req;
  logic [15:0]              seed_eff;
  logic [15:0]              lfsr_next;
  logic [CW-1:0]            rem_next;
  logic [CW-1:0]            placed_next;
  logic [VECTOR_LENGTH-1:0] work_next;

  // Per-cell decision for the current fill position, plus the load-time values.
  always_comb begin
    slots       = N_VAL - idx_reg;
    // Forced set when quota equals the remaining slots; otherwise the LFSR
    // value before the advance decides, as long as quota remains.
    set_bit     = (rem_reg == slots) || ((rem_reg != '0) && lfsr_reg[0]);
    rem_next    = rem_reg - CW'(set_bit);
    placed_next = placed_reg + CW'(set_bit);
    lfsr_next   = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    clamped_req = (ones_req > N_VAL) ? N_VAL : ones_req;
    // A zero seed would lock the LFSR at zero, so substitute the reset value.
    seed_eff    = (seed == 16'h0000) ? LFSR_RESET : seed;
  end

  // Only the cell addressed by idx takes the new decision; the others hold.
  generate
    for (genvar gi = 0; gi < VECTOR_LENGTH; gi++) begin : g_cell
      assign work_next[gi] = (idx_reg == CW'(gi)) ? set_bit : work_reg[gi];
    end
  endgenerate

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      rem_reg    <= '0;
      placed_reg <= '0;
      work_reg   <= '0;
      lfsr_reg   <= LFSR_RESET;
      busy       <= 1'b0;
      done       <= 1'b0;
      vector_out <= '0;
      count_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= FILL;
            busy       <= 1'b1;
            idx_reg    <= '0;
            work_reg   <= '0;
            placed_reg <= '0;
            rem_reg    <= clamped_req;
            lfsr_reg   <= seed_eff;
          end
        end
        FILL: begin
          work_reg   <= work_next;
          rem_reg    <= rem_next;
          placed_reg <= placed_next;
          lfsr_reg   <= lfsr_next;
          if (idx_reg == LAST_IDX) begin
            // Publish the completed row only; partial rows stay hidden.
            vector_out <= work_next;
            count_out  <= placed_next;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
